note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Pattern-driven note sequencer. It replaces the free-running sequence counter upstream of the notes ROM and PWM modulator.
- It steps through a pattern table of entries. Each entry is {rest, duration, note}. Timing is taken from the beat strobe.
- It drives the note index into the notes ROM, plus a gate that masks the PWM output during rests, articulation gaps, pause and stop.
- It supports play/pause, restart, loop and end-of-pattern markers.

Parameters:
- BW, 6, note index width and pattern address width.
- SEQ_LEN, 64, pattern length in entries. Address range is 0..SEQ_LEN-1.
- GAP_BW, 24, width of the articulation gap counter.
- GAP_CYC, 24'd12000, articulation gap length in clock cycles. A value of 0 is treated as 1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- strb_i  in  1  beat strobe, 1-cycle pulse.
- play_i  in  1  level: 1 = run, 0 = pause.
- restart_i  in  1  1-cycle pulse: restart from entry 0.
- loop_i  in  1  level: 1 = wrap to entry 0 at end of pattern.
- entry_i  in  10  pattern entry at addr_o, combinational read. Fields: [9] rest, [8:6] dur, [5:0] note.
- addr_o  out  BW  pattern address.
- noteIndex_o  out  BW  current note index, to the notes ROM.
- gate_o  out  1  1 = note sounding.
- busy_o  out  1  1 whenever state != IDLE.
- done_o  out  1  1-cycle pulse on non-looping end of pattern.

Behaviour:
- Reset: the single clock is clk_i. Reset is asynchronous and active-high on rst_i. On reset: state IDLE, addr_o=0, noteIndex_o=0, gate_o=0, busy_o=0, done_o=0, duration counter 0, gap counter 0.
- All other state changes are on the rising edge of clk_i. All outputs are registered, except busy_o, which is decoded from the state register.
- Entry encoding:
  - Duration is dur+1 strobes (1..8).
  - End marker is rest=1 and note=6'h3F. dur is ignored for the end marker.
- State machine: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE: gate_o=0. If play_i=1, go to LOAD.
- LOAD (1 cycle): sample entry_i at addr_o.
  - End marker at addr_o=0: go to DONE. This prevents an infinite loop on an empty pattern.
  - End marker at addr_o≠0: handled as end of pattern (see below).
  - Otherwise: latch noteIndex_o=note, rest flag=rest, duration counter=dur+1, go to PLAY. noteIndex_o updates on this edge. For a rest entry it keeps its previous value.
- PLAY: gate_o = ~rest flag.
  - On strb_i, decrement the duration counter.
  - When the counter is 1 and strb_i arrives, go to GAP and load the gap counter with max(GAP_CYC,1).
  - strb_i is ignored in every state except PLAY.
- GAP: gate_o=0. Decrement the gap counter each cycle. When it reaches 1, advance:
  - If addr_o==SEQ_LEN-1, handle as end of pattern.
  - Otherwise addr_o+1 and go to LOAD.
- End of pattern:
  - If loop_i=1: addr_o=0, go to LOAD.
  - Else: go to DONE.
  - loop_i is sampled at the moment of the decision.
- DONE (1 cycle): done_o=1, addr_o=0, gate_o=0, then IDLE. done_o is 0 in all other states.
- Pause: play_i=0 in LOAD, PLAY or GAP.
  - Freeze the state, addr_o, the duration counter and the gap counter. Force gate_o=0. Ignore strb_i.
  - When play_i=1 again, continue from the frozen point with the same counts.
  - busy_o stays 1 while paused.
- Restart: restart_i=1 in any state. It has the highest priority except reset.
  - Set addr_o=0 and gate_o=0. Clear the counters.
  - Next state is LOAD if play_i=1, else IDLE.
  - restart_i overrides a simultaneous strb_i or gap expiry.
- Simultaneous events:
  - strb_i together with play_i falling edge in PLAY: the pause wins and the strobe is lost.
  - play_i=0 in DONE: DONE still completes to IDLE.
- Latency:
  - play_i sampled 1 in IDLE: LOAD on the next edge, PLAY with gate_o=1 on the following edge. That is 2 cycles.
  - Last strobe of a note: gate_o falls on the same edge the state enters GAP.
- Widths:
  - The duration counter is 4 bits.
  - The gap counter is GAP_BW bits.
  - addr_o wraps only via the end-of-pattern rule and never overflows.

Test Plan:
- Setup for all cases: GAP_CYC=4, SEQ_LEN=4. Pattern: {0,3'd1,6'd5}, {1,3'd0,6'd0}, {0,3'd2,6'd9}, {0,3'd0,6'd7}.
- Basic playback: with loop_i=0, raise play_i, strobe every 20 cycles.
  - gate_o rises 2 cycles later with noteIndex_o=5, high for 2 strobes, then a 4-cycle gap.
  - Entry 1: gate_o=0 for 1 strobe, noteIndex_o stays 5.
  - Entry 2: noteIndex_o=9 for 3 strobes.
  - Entry 3: noteIndex_o=7 for 1 strobe.
  - After the final gap: done_o is a 1-cycle pulse, then busy_o=0 and addr_o=0.
- Loop: same as basic playback with loop_i=1. After entry 3's gap, addr_o=0, noteIndex_o=5, no done_o pulse.
- End marker: entry 2 set to {1,3'd0,6'h3F}, loop_i=0. After entry 1's gap: LOAD, then DONE and done_o, with no gate for entry 2.
- Empty pattern: entry 0 = end marker with loop_i=1. Result: done_o pulses once and the block returns to IDLE, with no hang.
- Pause and restart:
  - Drop play_i after 1 strobe of entry 2 and apply 3 strobes. gate_o=0, addr_o stays 2, and the note still needs 2 more strobes after resume.
  - Then pulse restart_i together with strb_i: addr_o=0, and LOAD for entry 0 follows.
- Reset mid-operation: assert rst_i asynchronously during PLAY, between clock edges. All outputs go to 0 immediately, without waiting for a clock edge, and state is IDLE.

Source files
------------

// File: rtl/note_sequencer.sv
// Pattern-driven note sequencer: walks {rest, dur, note} entries on beat strobes,
// drives the notes-ROM index and a gate that mutes rests, articulation gaps, pause and stop.
module note_sequencer #(
   parameter int unsigned       BW      = 6,
   parameter int unsigned       SEQ_LEN = 64,
   parameter int unsigned       GAP_BW  = 24,
   parameter logic [GAP_BW-1:0] GAP_CYC = 24'd12000
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          strb_i,
   input  logic          play_i,
   input  logic          restart_i,
   input  logic          loop_i,
   input  logic [9:0]    entry_i,
   output logic [BW-1:0] addr_o,
   output logic [BW-1:0] noteIndex_o,
   output logic          gate_o,
   output logic          busy_o,
   output logic          done_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_PLAY,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [GAP_BW-1:0] GAP_LOAD  = (GAP_CYC == '0) ? GAP_BW'(1) : GAP_CYC;
   localparam logic [BW-1:0]     LAST_ADDR = BW'(SEQ_LEN - 1);

   state_t              r_state;
   logic [BW-1:0]       r_addr;
   logic [BW-1:0]       r_note;
   logic                r_rest;
   logic [3:0]          r_dur;
   logic [GAP_BW-1:0]   r_gap;
   logic                r_gate;
   logic                r_done;

   state_t              w_state_nx;
   logic [BW-1:0]       w_addr_nx;
   logic [BW-1:0]       w_note_nx;
   logic                w_rest_nx;
   logic [3:0]          w_dur_nx;
   logic [GAP_BW-1:0]   w_gap_nx;
   logic                w_gate_nx;
   logic                w_done_nx;
   logic                w_eop;
   logic                w_end_mark;

   assign w_end_mark = entry_i[9] && (entry_i[5:0] == 6'h3F);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_addr  <= '0;
         r_note  <= '0;
         r_rest  <= 1'b0;
         r_dur   <= '0;
         r_gap   <= '0;
         r_gate  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_addr  <= w_addr_nx;
         r_note  <= w_note_nx;
         r_rest  <= w_rest_nx;
         r_dur   <= w_dur_nx;
         r_gap   <= w_gap_nx;
         r_gate  <= w_gate_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_note_nx  = r_note;
      w_rest_nx  = r_rest;
      w_dur_nx   = r_dur;
      w_gap_nx   = r_gap;
      w_gate_nx  = 1'b0;
      w_done_nx  = 1'b0;
      w_eop      = 1'b0;

      if (restart_i) begin
         w_addr_nx  = '0;
         w_dur_nx   = '0;
         w_gap_nx   = '0;
         w_state_nx = play_i ? S_LOAD : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (play_i) w_state_nx = S_LOAD;
            end
            S_LOAD: begin
               if (play_i) begin
                  if (w_end_mark) begin
                     // An end marker at entry 0 never loops, so an empty pattern cannot spin forever
                     if (r_addr == '0) w_state_nx = S_DONE;
                     else              w_eop      = 1'b1;
                  end else begin
                     if (!entry_i[9]) w_note_nx = BW'(entry_i[5:0]);
                     w_rest_nx  = entry_i[9];
                     w_dur_nx   = {1'b0, entry_i[8:6]} + 4'd1;
                     w_state_nx = S_PLAY;
                  end
               end
            end
            S_PLAY: begin
               if (play_i && strb_i) begin
                  w_dur_nx = r_dur - 4'd1;
                  if (r_dur == 4'd1) begin
                     w_gap_nx   = GAP_LOAD;
                     w_state_nx = S_GAP;
                  end
               end
            end
            S_GAP: begin
               if (play_i) begin
                  w_gap_nx = r_gap - GAP_BW'(1);
                  if (r_gap <= GAP_BW'(1)) begin
                     if (r_addr == LAST_ADDR) begin
                        w_eop = 1'b1;
                     end else begin
                        w_addr_nx  = r_addr + BW'(1);
                        w_state_nx = S_LOAD;
                     end
                  end
               end
            end
            S_DONE: begin
               w_state_nx = S_IDLE;
            end
            default: begin
               w_state_nx = S_IDLE;
            end
         endcase

         if (w_eop) begin
            if (loop_i) begin
               w_addr_nx  = '0;
               w_state_nx = S_LOAD;
            end else begin
               w_state_nx = S_DONE;
            end
         end
      end

      // Outputs are registered, so they are decoded from the state being entered
      if (w_state_nx == S_DONE) w_addr_nx = '0;
      w_done_nx = (w_state_nx == S_DONE);
      w_gate_nx = (w_state_nx == S_PLAY) && !w_rest_nx && play_i && !restart_i;
   end

   assign addr_o      = r_addr;
   assign noteIndex_o = r_note;
   assign gate_o      = r_gate;
   assign done_o      = r_done;
   assign busy_o      = (r_state != S_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: a hand-written vector table for pause/restart,
// an entry-walking timeline model for directed and random patterns, and an async reset check.
module tb_note_sequencer;

   localparam int MAXE    = 600;
   localparam int SEQ_LEN = 4;

   typedef struct packed {
      logic       gate;
      logic [5:0] note;
      logic [5:0] addr;
      logic       busy;
      logic       done;
   } out_t;

   typedef struct packed {
      logic strb;
      logic play;
      logic restart;
      out_t exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       strb;
   logic       play;
   logic       restart;
   logic       loop_l;
   logic [9:0] entry;
   logic [5:0] addr;
   logic [5:0] note;
   logic       gate;
   logic       busy;
   logic       done;

   logic [9:0] pat [SEQ_LEN];
   out_t       exp_a [MAXE];
   bit         strb_a [MAXE];
   vec_t       tbl [$];
   int         n_pass = 0;
   int         n_chk  = 0;

   always #5 clk = ~clk;

   assign entry = pat[addr[1:0]];

   note_sequencer #(
      .BW      (6),
      .SEQ_LEN (SEQ_LEN),
      .GAP_BW  (24),
      .GAP_CYC (24'd4)
   ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .strb_i      (strb),
      .play_i      (play),
      .restart_i   (restart),
      .loop_i      (loop_l),
      .entry_i     (entry),
      .addr_o      (addr),
      .noteIndex_o (note),
      .gate_o      (gate),
      .busy_o      (busy),
      .done_o      (done)
   );

   function automatic out_t mk(input logic g, input logic [5:0] n, input int a,
                               input logic b, input logic d);
      out_t o;
      o.gate = g;
      o.note = n;
      o.addr = 6'(a);
      o.busy = b;
      o.done = d;
      return o;
   endfunction

   function automatic out_t cur_out();
      return mk(gate, note, int'(addr), busy, done);
   endfunction

   task automatic check(input string name, input out_t act, input out_t expv);
      n_chk++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got gate=%b note=%0d addr=%0d busy=%b done=%b, expected gate=%b note=%0d addr=%0d busy=%b done=%b",
                    name, act.gate, act.note, act.addr, act.busy, act.done,
                    expv.gate, expv.note, expv.addr, expv.busy, expv.done);
   endtask

   task automatic put(input int e, input out_t v);
      if (e < MAXE) exp_a[e] = v;
   endtask

   // Walks the pattern entry by entry; exp_a[e] holds the outputs after clock edge e,
   // where edge 0 is the first edge that samples play=1 in idle.
   task automatic model(input bit lp, output int n);
      int         e = 0;
      int         a = 0;
      int         rem;
      bit         fin = 0;
      logic [5:0] nt = '0;
      logic [9:0] ent;
      put(e, mk(1'b0, nt, 0, 1'b1, 1'b0)); e++;
      while (!fin && e < MAXE) begin
         ent = pat[a];
         if (ent[9] && ent[5:0] == 6'h3F) begin
            if (a != 0 && lp) begin
               a = 0;
               put(e, mk(1'b0, nt, 0, 1'b1, 1'b0)); e++;
            end else begin
               put(e, mk(1'b0, nt, 0, 1'b1, 1'b1)); e++;
               put(e, mk(1'b0, nt, 0, 1'b0, 1'b0)); e++;
               fin = 1;
            end
         end else begin
            if (!ent[9]) nt = ent[5:0];
            rem = int'(ent[8:6]) + 1;
            put(e, mk(!ent[9], nt, a, 1'b1, 1'b0)); e++;
            while (rem > 0 && e < MAXE) begin
               if (strb_a[e]) rem--;
               put(e, mk((rem > 0) ? !ent[9] : 1'b0, nt, a, 1'b1, 1'b0)); e++;
            end
            for (int g = 0; g < 3; g++) begin
               put(e, mk(1'b0, nt, a, 1'b1, 1'b0)); e++;
            end
            if (a == SEQ_LEN - 1 && !lp) begin
               put(e, mk(1'b0, nt, 0, 1'b1, 1'b1)); e++;
               put(e, mk(1'b0, nt, 0, 1'b0, 1'b0)); e++;
               fin = 1;
            end else begin
               a = (a == SEQ_LEN - 1) ? 0 : a + 1;
               put(e, mk(1'b0, nt, a, 1'b1, 1'b0)); e++;
            end
         end
      end
      n = (!fin || e > MAXE) ? MAXE : e;
   endtask

   task automatic reset_dut();
      rst     = 1'b1;
      strb    = 1'b0;
      play    = 1'b0;
      restart = 1'b0;
      loop_l  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic set_base();
      pat[0] = {1'b0, 3'd1, 6'd5};
      pat[1] = {1'b1, 3'd0, 6'd0};
      pat[2] = {1'b0, 3'd2, 6'd9};
      pat[3] = {1'b0, 3'd0, 6'd7};
   endtask

   task automatic run_scenario(input string name, input bit lp);
      int n;
      model(lp, n);
      reset_dut();
      loop_l = lp;
      for (int e = 0; e < n; e++) begin
         strb = strb_a[e];
         play = 1'b1;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("%s[%0d]", name, e), cur_out(), exp_a[e]);
      end
      play = 1'b0;
      strb = 1'b0;
   endtask

   task automatic row(input logic s, input logic p, input logic r, input logic g,
                      input int nt, input int a, input logic b, input logic d);
      vec_t v;
      v.strb    = s;
      v.play    = p;
      v.restart = r;
      v.exp     = mk(g, 6'(nt), a, b, d);
      tbl.push_back(v);
   endtask

   initial begin
      // strb play restart | gate note addr busy done (outputs after the edge)
      row(0, 1, 0,  0, 0, 0, 1, 0);  // idle -> load
      row(0, 1, 0,  1, 5, 0, 1, 0);  // play entry 0
      row(1, 1, 0,  1, 5, 0, 1, 0);  // first strobe
      row(0, 0, 0,  0, 5, 0, 1, 0);  // pause mutes gate
      row(1, 0, 0,  0, 5, 0, 1, 0);  // strobe while paused is lost
      row(0, 1, 0,  1, 5, 0, 1, 0);  // resume
      row(1, 1, 0,  0, 5, 0, 1, 0);  // second strobe ends note
      row(0, 0, 0,  0, 5, 0, 1, 0);  // gap frozen
      row(0, 1, 0,  0, 5, 0, 1, 0);
      row(0, 1, 0,  0, 5, 0, 1, 0);
      row(0, 1, 0,  0, 5, 0, 1, 0);
      row(0, 1, 0,  0, 5, 1, 1, 0);  // advance to entry 1
      row(1, 1, 0,  0, 5, 1, 1, 0);  // strobe in load ignored; rest keeps note
      row(1, 1, 0,  0, 5, 1, 1, 0);  // rest ends
      row(0, 1, 0,  0, 5, 1, 1, 0);
      row(0, 1, 0,  0, 5, 1, 1, 0);
      row(0, 1, 0,  0, 5, 1, 1, 0);
      row(0, 1, 0,  0, 5, 2, 1, 0);  // load entry 2
      row(0, 1, 0,  1, 9, 2, 1, 0);
      row(1, 1, 1,  0, 9, 0, 1, 0);  // restart beats strobe
      row(0, 1, 0,  1, 5, 0, 1, 0);  // entry 0 again
      row(0, 0, 1,  0, 5, 0, 0, 0);  // restart without play -> idle
      row(0, 0, 0,  0, 5, 0, 0, 0);

      set_base();
      reset_dut();
      check("reset_state", cur_out(), mk(1'b0, 6'd0, 0, 1'b0, 1'b0));
      foreach (tbl[i]) begin
         strb    = tbl[i].strb;
         play    = tbl[i].play;
         restart = tbl[i].restart;
         @(posedge clk);
         @(negedge clk);
         check($sformatf("table[%0d]", i), cur_out(), tbl[i].exp);
      end
      restart = 1'b0;

      for (int e = 0; e < MAXE; e++) strb_a[e] = ((e % 20) == 19);
      set_base();
      run_scenario("basic", 1'b0);
      run_scenario("loop", 1'b1);
      pat[2] = {1'b1, 3'd0, 6'h3F};
      run_scenario("endmark", 1'b0);
      set_base();
      pat[0] = {1'b1, 3'd5, 6'h3F};
      run_scenario("empty", 1'b1);

      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < SEQ_LEN; i++) begin
            if ($urandom_range(0, 4) == 0) pat[i] = {1'b1, 3'($urandom), 6'h3F};
            else                           pat[i] = 10'($urandom);
         end
         for (int e = 0; e < MAXE; e++) strb_a[e] = ($urandom_range(0, 2) == 0);
         run_scenario($sformatf("rand%0d", s), 1'($urandom_range(0, 1)));
      end

      set_base();
      reset_dut();
      play = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("pre_async_reset", cur_out(), mk(1'b1, 6'd5, 0, 1'b1, 1'b0));
      @(posedge clk);
      #3 rst = 1'b1;
      #1 check("async_reset", cur_out(), mk(1'b0, 6'd0, 0, 1'b0, 1'b0));
      play = 1'b0;
      @(negedge clk);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
